dcu: RTL and testbench
======================

DCU -- requirements
Module: dcu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: beat strobe for din and kin.
REQ-004 SHALL have port din, input, 4 bits: one ciphertext nibble per beat, most-significant nibble first.
REQ-005 SHALL have port kin, input, 4 bits: one key nibble per beat, most-significant nibble first.
REQ-006 SHALL have port dout, output, 4 bits: one plaintext nibble per out_valid cycle, most-significant nibble first; 0 when out_valid=0.
REQ-007 SHALL have port out_valid, output, 1 bit: dout holds a valid plaintext nibble.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE and LOAD.

Function
REQ-009 SHALL implement Mini-AES decryption: 16-bit block, 16-bit key, nibbles n0..n3 with n0 = bits 15:12.
- Matrix columns: (n0,n1) and (n2,n3).
- SR swaps n1 and n3.
- MC multiplies each column by [[3,2],[2,3]] over GF(2^4) modulo x^4+x+1.
- SR and MC are self-inverse.
REQ-010 SHALL use inverse S-box, input 0..F mapped to: E,3,4,8,1,C,A,F,7,D,9,6,B,2,0,5.
REQ-011 SHALL expand the key with forward S-box E,4,D,1,2,F,B,8,3,A,6,C,5,9,0,7:
- K0 = w0..w3.
- w4 = w0^S(w3)^1; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
- w8 = w4^S(w7)^2; w9 = w5^w8; w10 = w6^w9; w11 = w7^w10.
- K1 = w4..w7; K2 = w8..w11.
REQ-012 SHALL sequence the FSM IDLE -> LOAD -> KEY1 -> KEY2 -> R2 -> R1 -> R0 -> OUT -> IDLE, one cycle per state except LOAD and OUT.
REQ-013 SHALL, in IDLE or LOAD, shift din and kin into the state and key registers on each in_valid=1 cycle, counting beats 0..3.
- Gaps with in_valid=0 hold the beat count.
- The 4th beat moves the FSM to KEY1.
REQ-014 SHALL compute K1 in KEY1 and K2 in KEY2.
REQ-015 SHALL apply, per state:
- R2: AddKey K2, SR, inverse S-box.
- R1: AddKey K1, MC, SR, inverse S-box.
- R0: AddKey K0.
REQ-016 SHALL, in OUT, assert out_valid for exactly 4 consecutive cycles presenting p0, p1, p2, p3, then return to IDLE with the beat count at 0.
REQ-017 SHALL assert the first out_valid cycle exactly 6 rising edges after the edge that samples beat 4.
REQ-018 SHALL ignore in_valid while busy=1 or out_valid=1; ignored beats are not buffered.
REQ-019 SHALL accept a new beat 0 in the cycle immediately after the last OUT cycle.
REQ-020 SHALL drive dout and out_valid from registers.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-operation, immediately force:
- FSM to IDLE and beat count to 0;
- state and key registers to 0;
- dout=0, out_valid=0, busy=0.
REQ-022 SHALL resume at the first rising edge after rst_n deasserts, with no partial block retained.

Configuration
REQ-023 SHALL, when DCU_ERR_EN is defined, add output err (1 bit, reset 0).
- err pulses high for one cycle after any cycle where in_valid=1 is ignored per REQ-018.
- Without the macro the err port does not exist and behaviour is otherwise identical.

Verification
REQ-024 SHALL cover: beats (din,kin) = (7,C),(2,3),(C,F),(6,0) -> out_valid for 4 cycles, dout 9,C,6,3, first valid 6 edges after beat 4.
REQ-025 SHALL cover: same block with in_valid=0 gaps of 3 cycles between beats -> identical plaintext 9C63, latency measured from beat 4.
REQ-026 SHALL cover: ciphertext 0000, key 0000 -> plaintext equal to an independent model result; back-to-back second block started the cycle after OUT -> both blocks correct.
REQ-027 SHALL cover: rst_n low during R1 -> outputs 0 immediately, no out_valid afterwards; next full block decrypts correctly.
REQ-028 SHALL cover: in_valid=1 with din=F during KEY2 -> result still 9C63; with DCU_ERR_EN, err=1 for one cycle.
REQ-029 SHALL cover: 1000 random block/key pairs against a reference Mini-AES encrypt-then-decrypt model -> all plaintexts match.

Source files
------------

// File: rtl/dcu_if.sv
// DCU bus interface: nibble-serial ciphertext/key input and plaintext output.
// The optional err output exists only when DCU_ERR_EN is defined.
interface dcu_if;
    logic       in_valid;
    logic [3:0] din;
    logic [3:0] kin;
    logic [3:0] dout;
    logic       out_valid;
    logic       busy;
`ifdef DCU_ERR_EN
    logic       err;

    modport master (output in_valid, din, kin, input dout, out_valid, busy, err);
    modport slave  (input in_valid, din, kin, output dout, out_valid, busy, err);
`else
    modport master (output in_valid, din, kin, input dout, out_valid, busy);
    modport slave  (input in_valid, din, kin, output dout, out_valid, busy);
`endif
endinterface

// File: rtl/dcu.sv
// DCU: Mini-AES (16-bit block, 16-bit key) decryption unit.
// Four nibble beats load ciphertext and key; round keys are expanded on the fly,
// three decryption rounds run one per cycle and the plaintext streams out as
// four nibbles, most-significant first.
// Optional feature: define DCU_ERR_EN to add an err pulse for ignored beats.
module dcu (
    input  logic clk,
    input  logic rst_n,
    dcu_if.slave bus
);
    // Forward and inverse S-boxes, entry for input x at bit offset 4*(15-x).
    localparam logic [63:0] SBOX  = 64'hE4D12FB83A6C5907;
    localparam logic [63:0] ISBOX = 64'hE3481CAF7D96B205;

    typedef enum logic [2:0] {
        StIdle, StLoad, StKey1, StKey2, StR2, StR1, StR0, StOut
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] inv_sub(input logic [15:0] s);
        return {ISBOX[{~s[15:12], 2'b00} +: 4], ISBOX[{~s[11:8], 2'b00} +: 4],
                ISBOX[{~s[7:4], 2'b00} +: 4],   ISBOX[{~s[3:0], 2'b00} +: 4]};
    endfunction

    // Multiply by x in GF(2^4) modulo x^4+x+1.
    function automatic logic [3:0] gm2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    // Columns (n0,n1),(n2,n3) times [[3,2],[2,3]]; self-inverse.
    function automatic logic [15:0] mix(input logic [15:0] s);
        logic [3:0] a, b, c, d;
        a = s[15:12];
        b = s[11:8];
        c = s[7:4];
        d = s[3:0];
        return {gm2(a) ^ a ^ gm2(b), gm2(a) ^ gm2(b) ^ b,
                gm2(c) ^ c ^ gm2(d), gm2(c) ^ gm2(d) ^ d};
    endfunction

    // Swap n1 and n3.
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] key_step(input logic [15:0] k, input logic [3:0] rc);
        logic [3:0] a, b, c, d;
        a = k[15:12] ^ sbox(k[3:0]) ^ rc;
        b = k[11:8] ^ a;
        c = k[7:4] ^ b;
        d = k[3:0] ^ c;
        return {a, b, c, d};
    endfunction

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_blk, w_blk_nxt;
    logic [15:0] r_k0, w_k0_nxt;
    logic [15:0] r_k1, w_k1_nxt;
    logic [15:0] r_k2, w_k2_nxt;
    logic [3:0]  r_dout, w_dout_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        w_busy;
    logic        w_accept;

    assign w_busy   = (r_state != StIdle) && (r_state != StLoad);
    // Beats are taken only while idle/loading and not still presenting output.
    assign w_accept = bus.in_valid && !w_busy && !r_out_valid;

    // Next-state and datapath: one transform per state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_blk_nxt       = r_blk;
        w_k0_nxt        = r_k0;
        w_k1_nxt        = r_k1;
        w_k2_nxt        = r_k2;
        w_dout_nxt      = 4'h0;
        w_out_valid_nxt = 1'b0;
        unique case (r_state)
            StIdle, StLoad: begin
                if (w_accept) begin
                    w_blk_nxt = {r_blk[11:0], bus.din};
                    w_k0_nxt  = {r_k0[11:0], bus.kin};
                    w_cnt_nxt = r_cnt + 2'd1;
                    w_state_nxt = (r_cnt == 2'd3) ? StKey1 : StLoad;
                end
            end
            StKey1: begin
                w_k1_nxt    = key_step(r_k0, 4'h1);
                w_state_nxt = StKey2;
            end
            StKey2: begin
                w_k2_nxt    = key_step(r_k1, 4'h2);
                w_state_nxt = StR2;
            end
            StR2: begin
                w_blk_nxt   = inv_sub(shift_rows(r_blk ^ r_k2));
                w_state_nxt = StR1;
            end
            StR1: begin
                w_blk_nxt   = inv_sub(shift_rows(mix(r_blk ^ r_k1)));
                w_state_nxt = StR0;
            end
            StR0: begin
                w_blk_nxt   = r_blk ^ r_k0;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = StOut;
            end
            StOut: begin
                w_dout_nxt      = r_blk[15:12];
                w_out_valid_nxt = 1'b1;
                w_blk_nxt       = {r_blk[11:0], 4'h0};
                w_cnt_nxt       = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State, key and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 2'd0;
            r_blk       <= 16'h0;
            r_k0        <= 16'h0;
            r_k1        <= 16'h0;
            r_k2        <= 16'h0;
            r_dout      <= 4'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_blk       <= w_blk_nxt;
            r_k0        <= w_k0_nxt;
            r_k1        <= w_k1_nxt;
            r_k2        <= w_k2_nxt;
            r_dout      <= w_dout_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.dout      = r_dout;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = w_busy;

`ifdef DCU_ERR_EN
    logic r_err;

    // One-cycle flag for any beat dropped while busy or presenting output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= bus.in_valid && (w_busy || r_out_valid);
        end
    end

    assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_dcu.sv
// Directed and randomised bench for the DCU Mini-AES decryption unit.
module tb_dcu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    dcu_if bus_if ();

    dcu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference Mini-AES encryption model.
    logic [3:0] sb_tbl [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};

    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r = 4'h0;
        logic [3:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] s);
        return {sb_tbl[s[15:12]], sb_tbl[s[11:8]], sb_tbl[s[7:4]], sb_tbl[s[3:0]]};
    endfunction

    function automatic logic [15:0] m_sr(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] m_mc(input logic [15:0] s);
        return {m_mul(4'h3, s[15:12]) ^ m_mul(4'h2, s[11:8]),
                m_mul(4'h2, s[15:12]) ^ m_mul(4'h3, s[11:8]),
                m_mul(4'h3, s[7:4]) ^ m_mul(4'h2, s[3:0]),
                m_mul(4'h2, s[7:4]) ^ m_mul(4'h3, s[3:0])};
    endfunction

    function automatic logic [15:0] m_kx(input logic [15:0] k, input logic [3:0] rc);
        logic [15:0] o;
        o[15:12] = k[15:12] ^ sb_tbl[k[3:0]] ^ rc;
        o[11:8]  = k[11:8] ^ o[15:12];
        o[7:4]   = k[7:4] ^ o[11:8];
        o[3:0]   = k[3:0] ^ o[7:4];
        return o;
    endfunction

    function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [15:0] k);
        logic [15:0] k1, k2, s;
        k1 = m_kx(k, 4'h1);
        k2 = m_kx(k1, 4'h2);
        s  = p ^ k;
        s  = m_mc(m_sr(m_sub(s))) ^ k1;
        s  = m_sr(m_sub(s)) ^ k2;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [15:0] c, input logic [15:0] k, input int gap);
        for (int i = 0; i < 4; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.din      = c[15-4*i -: 4];
            bus_if.kin      = k[15-4*i -: 4];
            tick();
            bus_if.in_valid = 1'b0;
            bus_if.din      = 4'h0;
            bus_if.kin      = 4'h0;
            if (i < 3) repeat (gap) tick();
        end
    endtask

    // Called right after the edge sampling beat 4. Optionally drives a stray
    // F/F beat sampled at edge 'inject'. Bounded wait for out_valid.
    task automatic collect(input int inject, output logic [15:0] p, output int lat,
                           output int err_seen, output bit ok);
        p = 16'h0;
        lat = 0;
        err_seen = 0;
        ok = 1'b0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            if (n == inject) begin
                bus_if.in_valid = 1'b1;
                bus_if.din      = 4'hF;
                bus_if.kin      = 4'hF;
            end
            tick();
            bus_if.in_valid = 1'b0;
`ifdef DCU_ERR_EN
            if (bus_if.err) err_seen++;
`endif
            if (bus_if.out_valid) lat = n;
        end
        if (lat == 0) return;
        p = {12'h0, bus_if.dout};
        for (int j = 1; j < 4; j++) begin
            tick();
            if (!bus_if.out_valid) return;
            p = {p[11:0], bus_if.dout};
        end
        tick();
        ok = !bus_if.out_valid && (bus_if.dout == 4'h0);
    endtask

    task automatic test_reset();
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.dout !== 4'h0) begin
            errors++;
            $display("FAIL reset_dout got %h want 0", bus_if.dout);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus_if.busy);
        end
`ifdef DCU_ERR_EN
        checks++;
        if (bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", bus_if.err);
        end
`endif
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat, es;
        bit ok;
        send_beats(16'h72C6, 16'hC3F0, 0);
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b want 1", bus_if.busy);
        end
        collect(0, p, lat, es, ok);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
        checks++;
        if (p !== 16'h9C63 || !ok) begin
            errors++;
            $display("FAIL basic_plain got %h ok=%0d want 9c63 ok=1", p, ok);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] p;
        int lat, es;
        bit ok;
        tick();
        send_beats(16'h72C6, 16'hC3F0, 3);
        collect(0, p, lat, es, ok);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL gaps_latency got %0d want 6", lat);
        end
        checks++;
        if (p !== 16'h9C63 || !ok) begin
            errors++;
            $display("FAIL gaps_plain got %h ok=%0d want 9c63 ok=1", p, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat, es;
        bit ok;
        tick();
        send_beats(16'h0000, 16'h0000, 0);
        collect(0, p, lat, es, ok);
        checks++;
        if (p !== 16'hBDBD || !ok) begin
            errors++;
            $display("FAIL zero_plain got %h ok=%0d want bdbd ok=1", p, ok);
        end
        checks++;
        if (m_enc(p, 16'h0000) !== 16'h0000) begin
            errors++;
            $display("FAIL zero_model got %h want 0000", m_enc(p, 16'h0000));
        end
        // Next block starts on the very cycle after the last output nibble.
        send_beats(16'h72C6, 16'hC3F0, 0);
        collect(0, p, lat, es, ok);
        checks++;
        if (p !== 16'h9C63 || !ok || lat != 6) begin
            errors++;
            $display("FAIL b2b_plain got %h lat=%0d ok=%0d want 9c63 lat=6 ok=1", p, lat, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat, es, seen;
        bit ok;
        tick();
        send_beats(16'h72C6, 16'hC3F0, 0);
        repeat (3) tick();
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL r1_busy got %b want 1", bus_if.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0 || bus_if.dout !== 4'h0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b ov=%b dout=%h want 0 0 0",
                     bus_if.busy, bus_if.out_valid, bus_if.dout);
        end
        tick();
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (bus_if.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_output got %0d valid cycles want 0", seen);
        end
        send_beats(16'h72C6, 16'hC3F0, 0);
        collect(0, p, lat, es, ok);
        checks++;
        if (p !== 16'h9C63 || !ok || lat != 6) begin
            errors++;
            $display("FAIL midreset_recover got %h lat=%0d ok=%0d want 9c63 lat=6 ok=1",
                     p, lat, ok);
        end
    endtask

    task automatic test_ignore();
        logic [15:0] p;
        int lat, es;
        bit ok;
        tick();
        send_beats(16'h72C6, 16'hC3F0, 0);
        collect(2, p, lat, es, ok);
        checks++;
        if (p !== 16'h9C63 || !ok || lat != 6) begin
            errors++;
            $display("FAIL ignore_plain got %h lat=%0d ok=%0d want 9c63 lat=6 ok=1", p, lat, ok);
        end
`ifdef DCU_ERR_EN
        checks++;
        if (es != 1) begin
            errors++;
            $display("FAIL ignore_err got %0d cycles want 1", es);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] p, k, c, got;
        int lat, es;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            p = 16'($urandom);
            k = 16'($urandom);
            c = m_enc(p, k);
            send_beats(c, k, 0);
            collect(0, got, lat, es, ok);
            checks++;
            if (got !== p || !ok || lat != 6) begin
                errors++;
                $display("FAIL random_%0d got %h lat=%0d ok=%0d want %h lat=6 ok=1",
                         i, got, lat, ok, p);
            end
        end
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.din      = 4'h0;
        bus_if.kin      = 4'h0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
